// File: rtl/mem_arbiter_if.sv
// Requester handshakes, fill control and the shared single-port memory bus.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WORD_SIZE = 8
);
  // Requester A
  logic                 a_req;
  logic                 a_wr;
  logic [ADDR_SIZE-1:0] a_addr;
  logic [WORD_SIZE-1:0] a_wdata;
  logic                 a_ack;
  // Requester B
  logic                 b_req;
  logic                 b_wr;
  logic [ADDR_SIZE-1:0] b_addr;
  logic [WORD_SIZE-1:0] b_wdata;
  logic                 b_ack;
  // Shared read data and status
  logic [WORD_SIZE-1:0] rdata;
  logic                 fill_start;
  logic                 busy;
  logic                 fill_done;
  // Memory port
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_din;
  logic [WORD_SIZE-1:0] mem_dout;
  logic                 mem_wr;
  logic                 mem_cs;

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    input  b_req, b_wr, b_addr, b_wdata,
    input  fill_start, mem_dout,
    output a_ack, b_ack, rdata, busy, fill_done,
    output mem_addr, mem_din, mem_wr, mem_cs
  );

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    output b_req, b_wr, b_addr, b_wdata,
    output fill_start, mem_dout,
    input  a_ack, b_ack, rdata, busy, fill_done,
    input  mem_addr, mem_din, mem_wr, mem_cs
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory, with a whole-memory pattern
// fill (word i <- 2*i). Every output is a flop; each access takes IDLE ->
// ACCESS -> ACK, and simultaneous requests alternate between A and B.
module mem_arbiter #(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned MEM_SIZE  = 1024
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned    CntW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_SIZE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StAck,
    StFill
  } state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;  // 0 = A, 1 = B
  logic                 grant_q, grant_d;            // requester being served
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 a_ack_q, a_ack_d;
  logic                 b_ack_q, b_ack_d;
  logic                 busy_q, busy_d;
  logic                 fill_done_q, fill_done_d;
  // The memory-port flops double as the latched operands of the granted access.
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_din_q, mem_din_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 mem_cs_q, mem_cs_d;
  logic                 pick_b;

  // Next-state: arbitration, access sequencing and fill address generation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    fill_done_d  = 1'b0;
    mem_cs_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    pick_b       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.fill_start) begin
          // Fill wins over any pending request; requests wait in IDLE.
          state_d    = StFill;
          cnt_d      = '0;
          mem_cs_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_addr_d = '0;
          mem_din_d  = '0;
        end else if (bus.a_req || bus.b_req) begin
          // On contention, serve whoever was not granted last.
          pick_b       = bus.b_req && (!bus.a_req || !last_grant_q);
          grant_d      = pick_b;
          last_grant_d = pick_b;
          state_d      = StAccess;
          mem_cs_d     = 1'b1;
          mem_wr_d     = pick_b ? bus.b_wr    : bus.a_wr;
          mem_addr_d   = pick_b ? bus.b_addr  : bus.a_addr;
          mem_din_d    = pick_b ? bus.b_wdata : bus.a_wdata;
        end
      end

      StAccess: begin
        state_d = StAck;
        if (!mem_wr_q) begin
          rdata_d = bus.mem_dout;
        end
        a_ack_d = !grant_q;
        b_ack_d = grant_q;
      end

      StAck: begin
        state_d = StIdle;
      end

      StFill: begin
        if (cnt_q == CntLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          fill_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          mem_cs_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_addr_d = ADDR_SIZE'(cnt_d);
          // Left shift by one is 2*i, truncated to the word width.
          mem_din_d  = WORD_SIZE'({cnt_d, 1'b0});
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; synchronous reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
      fill_done_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_wr_q     <= 1'b0;
      mem_cs_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      busy_q       <= busy_d;
      fill_done_q  <= fill_done_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_wr_q     <= mem_wr_d;
      mem_cs_q     <= mem_cs_d;
    end
  end

  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.fill_done = fill_done_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_cs    = mem_cs_q;

  // Completion pulses are mutually exclusive.
  assert property (@(posedge clk) disable iff (rst) !(a_ack_q && b_ack_q));
  assert property (@(posedge clk) disable iff (rst) !((a_ack_q || b_ack_q) && fill_done_q));

endmodule
